// File: rtl/ccu_dac_write_sched.sv
// DAC write transaction scheduler: waits for FIFO data, fires the DAC write FSM,
// collects finish/error/timeout, retries after errors and reports the result.
module ccu_dac_write_sched #(
  parameter int unsigned LEN_W     = 8,
  parameter int unsigned LVL_W     = 9,
  parameter int unsigned TIMEOUT   = 4096,
  parameter int unsigned MAX_RETRY = 2,
  parameter int unsigned RETRY_GAP = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic [LVL_W-1:0] fifo_level,
  output logic             ctrl_writedac_dv,
  input  logic             int_writedac_finish,
  input  logic             int_writedac_err,
  input  logic             abort,
  output logic             sts_busy,
  output logic             sts_done,
  output logic             sts_err,
  output logic [1:0]       sts_err_code,
  output logic [15:0]      sts_tx_count
);

  localparam int unsigned CW = (LEN_W > LVL_W) ? LEN_W : LVL_W;
  localparam int unsigned TW = $clog2(TIMEOUT + RETRY_GAP + 1);
  localparam int unsigned RW = $clog2(MAX_RETRY + 2);

  localparam logic [1:0] CodeOk      = 2'd0;
  localparam logic [1:0] CodeErr     = 2'd1;
  localparam logic [1:0] CodeTimeout = 2'd2;
  localparam logic [1:0] CodeZeroLen = 2'd3;

  typedef enum logic [2:0] {
    StIdle,
    StWaitData,
    StStart,
    StWaitDone,
    StGap,
    StReport
  } state_e;

  state_e           state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [RW-1:0]    retry_q, retry_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic [1:0]       code_d;
  logic             level_ok;

  // Zero-extend both sides so differing widths compare correctly.
  assign level_ok = CW'(fifo_level) >= CW'(len_q);

  // Next-state logic; code_d is only meaningful on a transition into StReport.
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    retry_d = retry_q;
    timer_d = timer_q;
    code_d  = CodeOk;
    case (state_q)
      StIdle: begin
        if (cmd_valid && cmd_ready) begin
          len_d   = cmd_len;
          retry_d = '0;
          if (cmd_len == '0) begin
            state_d = StReport;
            code_d  = CodeZeroLen;
          end else begin
            state_d = StWaitData;
          end
        end
      end
      StWaitData: begin
        if (level_ok) state_d = StStart;
      end
      StStart: begin
        // Timer counts cycles since the dv pulse; the first WAIT_DONE cycle is 1.
        timer_d = TW'(1);
        state_d = StWaitDone;
      end
      StWaitDone: begin
        timer_d = timer_q + TW'(1);
        if (int_writedac_finish && !int_writedac_err) begin
          state_d = StReport;
          code_d  = CodeOk;
        end else if (int_writedac_err) begin
          if (retry_q < RW'(MAX_RETRY)) begin
            retry_d = retry_q + RW'(1);
            timer_d = '0;
            state_d = StGap;
          end else begin
            state_d = StReport;
            code_d  = CodeErr;
          end
        end else if (timer_q == TW'(TIMEOUT - 1)) begin
          state_d = StReport;
          code_d  = CodeTimeout;
        end
      end
      StGap: begin
        if (timer_q == TW'(RETRY_GAP - 1)) begin
          state_d = StWaitData;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      StReport: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
    // Abort overrides everything; the dv register already reflects a START cycle.
    if (abort && (state_q != StIdle)) begin
      state_d = StIdle;
      code_d  = CodeOk;
    end
  end

  // State, datapath and registered outputs, all derived from the next state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q          <= StIdle;
      len_q            <= '0;
      retry_q          <= '0;
      timer_q          <= '0;
      cmd_ready        <= 1'b0;
      sts_busy         <= 1'b0;
      ctrl_writedac_dv <= 1'b0;
      sts_done         <= 1'b0;
      sts_err          <= 1'b0;
      sts_err_code     <= 2'd0;
      sts_tx_count     <= 16'd0;
    end else begin
      state_q          <= state_d;
      len_q            <= len_d;
      retry_q          <= retry_d;
      timer_q          <= timer_d;
      cmd_ready        <= (state_d == StIdle);
      sts_busy         <= (state_d != StIdle);
      ctrl_writedac_dv <= (state_d == StStart);
      sts_done         <= (state_d == StReport);
      sts_err          <= (state_d == StReport) && (code_d != CodeOk);
      if (state_d == StReport) begin
        sts_err_code <= code_d;
        if ((code_d == CodeOk) && (sts_tx_count != 16'hFFFF)) begin
          sts_tx_count <= sts_tx_count + 16'd1;
        end
      end
    end
  end

endmodule
